riscv_output_checker: RTL and testbench

//   Synthesizable self-check stage directly downstream of RISCV_TOP. Consumes the core's
//   NUM_INST, OUTPUT_PORT and HALT each cycle and compares OUTPUT_PORT against a loaded

---
 rtl/riscv_output_checker.sv | 147 ++++++++++++++
 tb/tb_riscv_output_checker.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_output_checker.sv
// Self-check stage behind the RISC-V core: walks a loaded table of (instruction count,
// expected output) checkpoints while the core runs and latches a pass/fail verdict.
module riscv_output_checker #(
   parameter int NUM_TEST   = 17,
   parameter int IDX_W      = 5,
   parameter int MAX_CYCLES = 100000
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_start,
   input  logic             i_tblWe,
   input  logic [31:0]      i_tblNumInst,
   input  logic [31:0]      i_tblAns,
   input  logic [31:0]      i_numInst,
   input  logic [31:0]      i_outputPort,
   input  logic             i_halt,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [1:0]       o_failCode,
   output logic [IDX_W-1:0] o_failIdx,
   output logic [31:0]      o_failVal,
   output logic [IDX_W:0]   o_passCnt,
   output logic [IDX_W:0]   o_tblCnt,
   output logic [31:0]      o_cycleCnt,
   output logic             o_cfgErr
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   localparam logic [IDX_W:0] LP_NUM_TEST   = (IDX_W+1)'(NUM_TEST);
   localparam logic [31:0]    LP_LAST_CYCLE = 32'(MAX_CYCLES - 1);

   logic [31:0]    r_tblN   [NUM_TEST];
   logic [31:0]    r_tblAns [NUM_TEST];
   state_t         r_state;
   logic [IDX_W:0] r_tblCnt;
   logic [IDX_W:0] r_passCnt;
   logic [31:0]    r_cycleCnt;
   logic [31:0]    r_lastN;
   logic [31:0]    r_failVal;
   logic [1:0]     r_failCode;
   logic [IDX_W-1:0] r_failIdx;
   logic           r_cfgErr;

   logic             w_wrFull, w_wrOrder, w_wrOk, w_wrBad;
   logic [IDX_W-1:0] w_ptrIdx;
   logic             w_pending, w_hit, w_good, w_skip, w_allDone;
   logic [31:0]      w_entN, w_entAns;
   logic [IDX_W:0]   w_nextPtr;

   // A load must fit and keep checkpoint counts strictly increasing.
   assign w_wrFull  = (r_tblCnt == LP_NUM_TEST);
   assign w_wrOrder = (r_tblCnt != '0) && (i_tblNumInst <= r_lastN);
   assign w_wrOk    = (r_state == S_IDLE) && i_tblWe && !w_wrFull && !w_wrOrder;
   assign w_wrBad   = (r_state == S_IDLE) && i_tblWe && (w_wrFull || w_wrOrder);

   assign w_ptrIdx  = r_passCnt[IDX_W-1:0];
   assign w_pending = (r_passCnt < r_tblCnt);
   assign w_entN    = w_pending ? r_tblN[w_ptrIdx]   : '0;
   assign w_entAns  = w_pending ? r_tblAns[w_ptrIdx] : '0;
   assign w_hit     = w_pending && (i_numInst == w_entN);
   assign w_good    = w_hit && (i_outputPort == w_entAns);
   assign w_skip    = w_pending && (i_numInst > w_entN);
   assign w_nextPtr = w_good ? r_passCnt + 1'b1 : r_passCnt;
   assign w_allDone = (w_nextPtr == r_tblCnt);

   // Table storage carries no reset; only entries below r_tblCnt are ever read.
   always_ff @(posedge i_clk) begin
      if (w_wrOk) begin
         r_tblN[r_tblCnt[IDX_W-1:0]]   <= i_tblNumInst;
         r_tblAns[r_tblCnt[IDX_W-1:0]] <= i_tblAns;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state    <= S_IDLE;
         r_tblCnt   <= '0;
         r_passCnt  <= '0;
         r_cycleCnt <= '0;
         r_lastN    <= '0;
         r_failCode <= '0;
         r_failIdx  <= '0;
         r_failVal  <= '0;
         r_cfgErr   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_wrOk) begin
                  r_tblCnt <= r_tblCnt + 1'b1;
                  r_lastN  <= i_tblNumInst;
               end
               if (w_wrBad)
                  r_cfgErr <= 1'b1;
               if (i_start && !r_cfgErr)
                  r_state <= S_RUN;
            end
            S_RUN: begin
               r_cycleCnt <= r_cycleCnt + 1'b1;
               if (w_hit && !w_good) begin
                  r_state    <= S_FAIL;
                  r_failCode <= 2'd0;
                  r_failIdx  <= w_ptrIdx;
                  r_failVal  <= i_outputPort;
               end else if (w_skip) begin
                  r_state    <= S_FAIL;
                  r_failCode <= 2'd1;
                  r_failIdx  <= w_ptrIdx;
                  r_failVal  <= i_numInst;
               end else begin
                  // A match this cycle still counts toward a same-cycle halt verdict.
                  r_passCnt <= w_nextPtr;
                  if (i_halt) begin
                     if (w_allDone) begin
                        r_state <= S_PASS;
                     end else begin
                        r_state    <= S_FAIL;
                        r_failCode <= 2'd2;
                        r_failIdx  <= w_nextPtr[IDX_W-1:0];
                        r_failVal  <= i_numInst;
                     end
                  end else if (r_cycleCnt == LP_LAST_CYCLE) begin
                     r_state    <= S_FAIL;
                     r_failCode <= 2'd3;
                     r_failIdx  <= w_nextPtr[IDX_W-1:0];
                     r_failVal  <= i_numInst;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy     = (r_state == S_RUN);
   assign o_done     = (r_state == S_PASS) || (r_state == S_FAIL);
   assign o_pass     = (r_state == S_PASS);
   assign o_failCode = r_failCode;
   assign o_failIdx  = r_failIdx;
   assign o_failVal  = r_failVal;
   assign o_passCnt  = r_passCnt;
   assign o_tblCnt   = r_tblCnt;
   assign o_cycleCnt = r_cycleCnt;
   assign o_cfgErr   = r_cfgErr;

endmodule

// File: tb/tb_riscv_output_checker.sv
// Bench for riscv_output_checker: a queue-based reference model checked every cycle,
// plus directed scenarios with literal expected verdicts.
module tb_riscv_output_checker;

   localparam int NUM_TEST   = 17;
   localparam int IDX_W      = 5;
   localparam int MAX_CYCLES = 10;

   logic             clk;
   logic             rstn;
   logic             start;
   logic             tblWe;
   logic [31:0]      tblNumInst;
   logic [31:0]      tblAns;
   logic [31:0]      numInst;
   logic [31:0]      outputPort;
   logic             halt;
   logic             busy;
   logic             done;
   logic             pass;
   logic [1:0]       failCode;
   logic [IDX_W-1:0] failIdx;
   logic [31:0]      failVal;
   logic [IDX_W:0]   passCnt;
   logic [IDX_W:0]   tblCnt;
   logic [31:0]      cycleCnt;
   logic             cfgErr;

   int nChecks = 0;
   int nErrors = 0;

   riscv_output_checker #(
      .NUM_TEST   (NUM_TEST),
      .IDX_W      (IDX_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .i_clk        (clk),
      .i_rstn       (rstn),
      .i_start      (start),
      .i_tblWe      (tblWe),
      .i_tblNumInst (tblNumInst),
      .i_tblAns     (tblAns),
      .i_numInst    (numInst),
      .i_outputPort (outputPort),
      .i_halt       (halt),
      .o_busy       (busy),
      .o_done       (done),
      .o_pass       (pass),
      .o_failCode   (failCode),
      .o_failIdx    (failIdx),
      .o_failVal    (failVal),
      .o_passCnt    (passCnt),
      .o_tblCnt     (tblCnt),
      .o_cycleCnt   (cycleCnt),
      .o_cfgErr     (cfgErr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the table is a pair of queues, progress is the number matched.
   typedef enum {M_IDLE, M_RUN, M_PASS, M_FAIL} mstate_t;
   mstate_t     mState;
   logic [31:0] mN[$];
   logic [31:0] mA[$];
   int          mMatched;
   bit          mCfgErr;
   int          mCode;
   int          mIdx;
   logic [31:0] mVal;
   int          mCycles;
   bit          mValid = 1'b0;

   task automatic modelFail(input int code, input logic [31:0] val);
      mState = M_FAIL;
      mCode  = code;
      mIdx   = mMatched;
      mVal   = val;
   endtask

   always @(posedge clk) begin : model
      bit oldErr;
      bit decided;
      if (!rstn) begin
         mState = M_IDLE; mN.delete(); mA.delete(); mMatched = 0; mCfgErr = 0;
         mCode = 0; mIdx = 0; mVal = 0; mCycles = 0; mValid = 1'b1;
      end else if (mState == M_IDLE) begin
         oldErr = mCfgErr;
         if (tblWe) begin
            if (mN.size() == NUM_TEST || (mN.size() > 0 && tblNumInst <= mN[mN.size()-1]))
               mCfgErr = 1'b1;
            else begin
               mN.push_back(tblNumInst);
               mA.push_back(tblAns);
            end
         end
         if (start && !oldErr) mState = M_RUN;
      end else if (mState == M_RUN) begin
         mCycles++;
         decided = 1'b0;
         if (mMatched < mN.size()) begin
            if (numInst == mN[mMatched]) begin
               if (outputPort == mA[mMatched]) mMatched++;
               else begin modelFail(0, outputPort); decided = 1'b1; end
            end else if (numInst > mN[mMatched]) begin
               modelFail(1, numInst); decided = 1'b1;
            end
         end
         if (!decided && halt) begin
            if (mMatched == mN.size()) mState = M_PASS;
            else modelFail(2, numInst);
            decided = 1'b1;
         end
         if (!decided && mCycles == MAX_CYCLES) modelFail(3, numInst);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      if (mValid) begin
         checkOutput("m.busy",     32'(busy),     32'(mState == M_RUN));
         checkOutput("m.done",     32'(done),     32'(mState == M_PASS || mState == M_FAIL));
         checkOutput("m.pass",     32'(pass),     32'(mState == M_PASS));
         checkOutput("m.failCode", 32'(failCode), 32'(mCode));
         checkOutput("m.failIdx",  32'(failIdx),  32'(mIdx));
         checkOutput("m.failVal",  failVal,       mVal);
         checkOutput("m.passCnt",  32'(passCnt),  32'(mMatched));
         checkOutput("m.tblCnt",   32'(tblCnt),   32'(mN.size()));
         checkOutput("m.cycleCnt", cycleCnt,      32'(mCycles));
         checkOutput("m.cfgErr",   32'(cfgErr),   32'(mCfgErr));
      end
   end

   task automatic applyStimulus(input logic [31:0] n, input logic [31:0] o, input logic h);
      numInst = n; outputPort = o; halt = h;
      @(negedge clk);
   endtask

   task automatic doReset();
      rstn = 1'b0; start = 1'b0; tblWe = 1'b0; halt = 1'b0; numInst = '0; outputPort = '0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic loadEntry(input logic [31:0] n, input logic [31:0] a);
      tblWe = 1'b1; tblNumInst = n; tblAns = a;
      @(negedge clk);
      tblWe = 1'b0;
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; tblWe = 1'b0; tblNumInst = '0; tblAns = '0;
      numInst = '0; outputPort = '0; halt = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("reset.busy",   32'(busy),   32'd0);
      checkOutput("reset.tblCnt", 32'(tblCnt), 32'd0);
      checkOutput("reset.cfgErr", 32'(cfgErr), 32'd0);

      $display("[TB] full pass with a stalled count");
      doReset();
      loadEntry(32'd4, 32'h0eec); loadEntry(32'd6, 32'd0);
      pulseStart();
      checkOutput("t1.busy", 32'(busy), 32'd1);
      applyStimulus(32'd4, 32'h0eec, 1'b0);
      applyStimulus(32'd4, 32'h0eec, 1'b0);
      applyStimulus(32'd6, 32'd0, 1'b0);
      applyStimulus(32'd6, 32'd0, 1'b1);
      checkOutput("t1.pass",     32'(pass),     32'd1);
      checkOutput("t1.passCnt",  32'(passCnt),  32'd2);
      checkOutput("t1.failCode", 32'(failCode), 32'd0);
      checkOutput("t1.cycleCnt", cycleCnt,      32'd4);
      applyStimulus(32'd9, 32'd1, 1'b0);
      checkOutput("t1.frozen", cycleCnt, 32'd4);

      $display("[TB] mismatch");
      doReset();
      loadEntry(32'd4, 32'h0eec); loadEntry(32'd6, 32'd0);
      pulseStart();
      applyStimulus(32'd4, 32'h0eec, 1'b0);
      applyStimulus(32'd6, 32'd5, 1'b0);
      checkOutput("t2.done",     32'(done),     32'd1);
      checkOutput("t2.failCode", 32'(failCode), 32'd0);
      checkOutput("t2.failIdx",  32'(failIdx),  32'd1);
      checkOutput("t2.failVal",  failVal,       32'd5);

      $display("[TB] skipped checkpoint");
      doReset();
      loadEntry(32'd4, 32'd1); loadEntry(32'd6, 32'd2);
      pulseStart();
      applyStimulus(32'd3, 32'd0, 1'b0);
      applyStimulus(32'd7, 32'd0, 1'b0);
      checkOutput("t3.failCode", 32'(failCode), 32'd1);
      checkOutput("t3.failIdx",  32'(failIdx),  32'd0);
      checkOutput("t3.failVal",  failVal,       32'd7);

      $display("[TB] early halt");
      doReset();
      loadEntry(32'd4, 32'hA); loadEntry(32'd6, 32'hB);
      pulseStart();
      applyStimulus(32'd4, 32'hA, 1'b0);
      applyStimulus(32'd5, 32'd0, 1'b1);
      checkOutput("t4.failCode", 32'(failCode), 32'd2);
      checkOutput("t4.passCnt",  32'(passCnt),  32'd1);
      checkOutput("t4.failVal",  failVal,       32'd5);

      $display("[TB] timeout");
      doReset();
      loadEntry(32'd4, 32'd1);
      pulseStart();
      for (int i = 0; i < 9; i++) applyStimulus(32'd4, 32'd1, 1'b0);
      checkOutput("t5.stillBusy", 32'(busy), 32'd1);
      applyStimulus(32'd4, 32'd1, 1'b0);
      checkOutput("t5.failCode", 32'(failCode), 32'd3);
      checkOutput("t5.cycleCnt", cycleCnt,      32'd10);
      checkOutput("t5.failIdx",  32'(failIdx),  32'd1);

      $display("[TB] table overflow");
      doReset();
      for (int i = 1; i <= 18; i++) loadEntry(32'(i), 32'(i * 3));
      checkOutput("t6.cfgErr", 32'(cfgErr), 32'd1);
      checkOutput("t6.tblCnt", 32'(tblCnt), 32'd17);
      pulseStart();
      applyStimulus(32'd0, 32'd0, 1'b0);
      checkOutput("t6.busy", 32'(busy), 32'd0);

      $display("[TB] non-increasing load");
      doReset();
      loadEntry(32'd8, 32'd1); loadEntry(32'd8, 32'd2);
      checkOutput("t7.cfgErr", 32'(cfgErr), 32'd1);
      checkOutput("t7.tblCnt", 32'(tblCnt), 32'd1);
      pulseStart();
      checkOutput("t7.busy", 32'(busy), 32'd0);

      $display("[TB] reset mid-run then rerun");
      doReset();
      for (int i = 1; i <= 4; i++) loadEntry(32'(i), 32'(i + 32'h100));
      pulseStart();
      for (int i = 1; i <= 3; i++) applyStimulus(32'(i), 32'(i + 32'h100), 1'b0);
      checkOutput("t8.passCnt3", 32'(passCnt), 32'd3);
      doReset();
      checkOutput("t8.busy",     32'(busy),     32'd0);
      checkOutput("t8.passCnt0", 32'(passCnt),  32'd0);
      checkOutput("t8.cycleCnt", cycleCnt,      32'd0);
      checkOutput("t8.tblCnt",   32'(tblCnt),   32'd0);
      for (int i = 1; i <= 4; i++) loadEntry(32'(i), 32'(i + 32'h100));
      pulseStart();
      for (int i = 1; i <= 4; i++) applyStimulus(32'(i), 32'(i + 32'h100), 1'b0);
      applyStimulus(32'd4, 32'h104, 1'b1);
      checkOutput("t8.pass", 32'(pass), 32'd1);

      $display("[TB] empty table");
      doReset();
      pulseStart();
      applyStimulus(32'd0, 32'd0, 1'b1);
      checkOutput("t9.pass",     32'(pass), 32'd1);
      checkOutput("t9.cycleCnt", cycleCnt,  32'd1);

      $display("[TB] mismatch with halt");
      doReset();
      loadEntry(32'd4, 32'd1); loadEntry(32'd6, 32'd2);
      pulseStart();
      applyStimulus(32'd4, 32'd1, 1'b0);
      applyStimulus(32'd6, 32'd9, 1'b1);
      checkOutput("t10.failCode", 32'(failCode), 32'd0);
      checkOutput("t10.failVal",  failVal,       32'd9);
      checkOutput("t10.pass",     32'(pass),     32'd0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
